// File: rtl/pitch_shifter_mc.sv
// Multi-channel pitch shifter: per-channel circular buffer, fractional read pointer, linear interpolation.
// Latency: out_ready rises 5 clock edges after the edge that samples in_ready; out_data is registered.
// No backpressure: in_ready while clearing or mid-sample is dropped and latches the sticky overrun flag.
module pitch_shifter_mc #(
   parameter int NUM_CH    = 2,
   parameter int DATA_SIZE = 24,
   parameter int ADDR_W    = 10,
   parameter int FRAC_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH*DATA_SIZE-1:0]   in_data,
   input  logic                          in_ready,
   input  logic [FRAC_W+1:0]             shift_factor,
   input  logic                          bypass,
   output logic [NUM_CH*DATA_SIZE-1:0]   out_data,
   output logic                          out_ready,
   output logic                          busy,
   output logic                          overrun
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int RW    = ADDR_W + FRAC_W;
   localparam int PW    = DATA_SIZE + FRAC_W + 2;
   localparam int BW    = NUM_CH * DATA_SIZE;

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_WRITE, S_RD_A, S_RD_B, S_CALC, S_OUT
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [RW-1:0]       rd_ptr_q;
   logic [BW-1:0]       smp_q;
   logic [FRAC_W+1:0]   sf_q;
   logic                byp_q;
   logic [BW-1:0]       a_q;
   logic [BW-1:0]       b_q;
   logic [BW-1:0]       out_data_q;
   logic                out_ready_q;
   logic                busy_q;
   logic                overrun_q;

   logic [DATA_SIZE-1:0] mem_q [NUM_CH][DEPTH];
   logic [BW-1:0]        ram_rdat_q;

   logic                ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_d;
   logic [BW-1:0]       ram_wdat_d;
   logic [BW-1:0]       y_d;

   logic [ADDR_W-1:0]   rd_int;
   logic [FRAC_W-1:0]   rd_frac;

   assign rd_int  = rd_ptr_q[RW-1:FRAC_W];
   assign rd_frac = rd_ptr_q[FRAC_W-1:0];

   assign out_data  = out_data_q;
   assign out_ready = out_ready_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

   // Buffer port steering: clear sweep, sample write, or the two interpolation taps
   always_comb begin
      ram_we_d   = 1'b0;
      ram_addr_d = rd_int;
      ram_wdat_d = '0;
      case (state_q)
         S_CLEAR: begin
            ram_we_d   = 1'b1;
            ram_addr_d = clr_cnt_q;
         end
         S_WRITE: begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_ptr_q;
            ram_wdat_d = smp_q;
         end
         S_RD_B:  ram_addr_d = rd_int + ADDR_W'(1);
         default: ram_addr_d = rd_int;
      endcase
   end

   // Per-channel buffers, synchronous read with one cycle of latency
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (ram_we_d) mem_q[k][ram_addr_d] <= ram_wdat_d[k*DATA_SIZE +: DATA_SIZE];
         ram_rdat_q[k*DATA_SIZE +: DATA_SIZE] <= mem_q[k][ram_addr_d];
      end
   end

   // y = A + floor((B-A)*frac / 2**FRAC_W); result stays between A and B so truncation is exact
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic signed [DATA_SIZE-1:0] a_s;
      logic signed [DATA_SIZE-1:0] b_s;
      logic signed [PW-1:0]        diff_s;
      logic signed [PW-1:0]        prod_s;
      logic signed [PW-1:0]        shf_s;
      assign a_s    = a_q[k*DATA_SIZE +: DATA_SIZE];
      assign b_s    = b_q[k*DATA_SIZE +: DATA_SIZE];
      assign diff_s = PW'(b_s) - PW'(a_s);
      assign prod_s = diff_s * $signed({{(PW-FRAC_W){1'b0}}, rd_frac});
      assign shf_s  = prod_s >>> FRAC_W;
      assign y_d[k*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(PW'(a_s) + shf_s);
   end

   // Control FSM with registered outputs and shared pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_CLEAR;
         clr_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         smp_q       <= '0;
         sf_q        <= '0;
         byp_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         out_data_q  <= '0;
         out_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         overrun_q   <= 1'b0;
      end else begin
         out_ready_q <= 1'b0;
         // A strobe that cannot be accepted is lost; remember that it happened
         if (in_ready && (state_q == S_CLEAR || state_q == S_WRITE || state_q == S_RD_A ||
                          state_q == S_RD_B  || state_q == S_CALC)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               if (clr_cnt_q == ADDR_W'(DEPTH-1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (in_ready) begin
                  smp_q   <= in_data;
                  sf_q    <= shift_factor;
                  byp_q   <= bypass;
                  busy_q  <= 1'b1;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: state_q <= S_RD_A;
            S_RD_A:  state_q <= S_RD_B;
            S_RD_B: begin
               a_q     <= ram_rdat_q;
               state_q <= S_CALC;
            end
            S_CALC: begin
               b_q     <= ram_rdat_q;
               state_q <= S_OUT;
            end
            S_OUT: begin
               out_data_q  <= byp_q ? smp_q : y_d;
               out_ready_q <= 1'b1;
               wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
               rd_ptr_q    <= rd_ptr_q + (byp_q ? (RW'(1) << FRAC_W) : RW'(sf_q));
               // A strobe arriving exactly at the minimum spacing starts the next sample
               if (in_ready) begin
                  smp_q   <= in_data;
                  sf_q    <= shift_factor;
                  byp_q   <= bypass;
                  state_q <= S_WRITE;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_shifter_mc.sv
// Bench for pitch_shifter_mc: directed scenarios then random samples against a buffer-level model.
// Timing: inputs driven and outputs sampled 1 time unit after the rising edge.
// All waits on the DUT are bounded; a timeout is reported as a failed check.
module tb_pitch_shifter_mc;

   localparam int NCH = 2;
   localparam int DS  = 24;
   localparam int AW  = 4;
   localparam int FW  = 8;
   localparam int DEP = 16;

   logic              clk;
   logic              rst;
   logic [NCH*DS-1:0] in_data;
   logic              in_ready;
   logic [FW+1:0]     shift_factor;
   logic              bypass;
   logic [NCH*DS-1:0] out_data;
   logic              out_ready;
   logic              busy;
   logic              overrun;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   // Reference model: buffer contents and pointers (read pointer in 1/256 units)
   longint mbuf [NCH][DEP];
   int     mwr;
   int     mrd;

   pitch_shifter_mc #(.NUM_CH(NCH), .DATA_SIZE(DS), .ADDR_W(AW), .FRAC_W(FW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready),
      .shift_factor(shift_factor), .bypass(bypass), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++)
         for (int a = 0; a < DEP; a++) mbuf[k][a] = 0;
      mwr = 0;
      mrd = 0;
   endtask

   // Expected output for one accepted sample; advances the model
   task automatic model_step(input longint x0, input longint x1, input int sf, input bit byp,
                             output longint e0, output longint e1);
      longint x [NCH];
      longint e [NCH];
      longint a, b, p, q;
      int ri, fr;
      x[0] = x0;
      x[1] = x1;
      for (int k = 0; k < NCH; k++) mbuf[k][mwr] = x[k];
      ri = mrd / 256;
      fr = mrd % 256;
      for (int k = 0; k < NCH; k++) begin
         if (byp) e[k] = x[k];
         else begin
            a = mbuf[k][ri];
            b = mbuf[k][(ri + 1) % DEP];
            p = (b - a) * fr;
            q = p / 256;
            if ((p % 256) != 0 && p < 0) q = q - 1;
            e[k] = a + q;
         end
      end
      mwr = (mwr + 1) % DEP;
      mrd = (mrd + (byp ? 256 : sf)) % (DEP * 256);
      e0 = e[0];
      e1 = e[1];
   endtask

   // Wait for out_ready, counting edges after the sampling edge; 'lat' is the count so far
   task automatic wait_strobe(inout int lat);
      while (out_ready !== 1'b1 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic send(input longint x0, input longint x1, input int sf, input bit byp,
                       output logic [DS-1:0] o0, output logic [DS-1:0] o1);
      longint e0, e1;
      int lat;
      model_step(x0, x1, sf, byp, e0, e1);
      @(posedge clk); #1;
      in_data      = {x1[DS-1:0], x0[DS-1:0]};
      shift_factor = sf[FW+1:0];
      bypass       = byp;
      in_ready     = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
      lat = 0;
      wait_strobe(lat);
      chk("latency", 64'(lat), 64'(5));
      chk("ch0_data", 64'(out_data[DS-1:0]), 64'(e0) & 64'hFFFFFF);
      chk("ch1_data", 64'(out_data[2*DS-1:DS]), 64'(e1) & 64'hFFFFFF);
      o0 = out_data[DS-1:0];
      o1 = out_data[2*DS-1:DS];
      @(posedge clk); #1;
      chk("strobe_one_cycle", 64'(out_ready), 64'(0));
   endtask

   task automatic release_clear(input bit inject);
      int cnt, strobes;
      cnt = 0;
      strobes = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (inject && cnt == 5) in_ready = 1'b1;
         @(posedge clk); #1;
         in_ready = 1'b0;
         if (out_ready === 1'b1) strobes++;
      end
      chk("clear_busy_cycles", 64'(cnt), 64'(16));
      chk("clear_overrun", 64'(overrun), 64'(inject));
      chk("clear_no_strobe", 64'(strobes), 64'(0));
      chk("clear_out_data", 64'(out_data), 64'(0));
   endtask

   task automatic do_reset(input bit inject);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_out_ready", 64'(out_ready), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_overrun", 64'(overrun), 64'(0));
      chk("rst_busy", 64'(busy), 64'(1));
      model_reset();
      #15;
      release_clear(inject);
   endtask

   initial begin
      logic [DS-1:0] o0, o1;
      logic [DS-1:0] r0, r1;
      longint e0, e1;
      int lat, strobes, sf;
      bit byp;
      longint uin0 [3] = '{100, 200, 300};
      longint uin1 [3] = '{-5, -6, -7};

      rst = 1'b0;
      in_ready = 1'b0;
      in_data = '0;
      shift_factor = 10'h100;
      bypass = 1'b0;
      model_reset();
      #23;
      chk("init_out_ready", 64'(out_ready), 64'(0));
      chk("init_out_data", 64'(out_data), 64'(0));
      chk("init_overrun", 64'(overrun), 64'(0));
      chk("init_busy", 64'(busy), 64'(1));
      release_clear(1'b0);

      // Unity rate reproduces the input
      for (int i = 0; i < 3; i++) begin
         send(uin0[i], uin1[i], 'h100, 1'b0, o0, o1);
         chk("unity_ch0", 64'(o0), 64'(uin0[i]) & 64'hFFFFFF);
         chk("unity_ch1", 64'(o1), 64'(uin1[i]) & 64'hFFFFFF);
      end

      // Half speed interpolates midpoints
      for (int i = 0; i < 5; i++) begin
         send(longint'(i * 1000), 0, 'h080, 1'b0, o0, o1);
         chk("half_ch0", 64'(o0), 64'(i * 500));
      end

      // Reset while a sample sits in RD_B aborts it and re-clears; strobe during clear flags overrun
      @(posedge clk); #1;
      in_data = {24'd77, 24'd77};
      shift_factor = 10'h100;
      bypass = 1'b0;
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
      @(posedge clk); #1;
      chk("midrst_no_strobe_rd_a", 64'(out_ready), 64'(0));
      do_reset(1'b1);

      // Signed interpolation uses floor rounding
      send(0, 0, 'h080, 1'b0, o0, o1);
      chk("floor_ch1_first", 64'(o1), 64'(0));
      send(0, -3, 'h080, 1'b0, o0, o1);
      chk("floor_ch1_second", 64'(o1), 64'hFFFFFE);

      // Strobe two cycles after an accepted one is dropped
      do_reset(1'b0);
      model_step(11, 12, 'h100, 1'b0, e0, e1);
      @(posedge clk); #1;
      in_data = {24'd12, 24'd11};
      shift_factor = 10'h100;
      bypass = 1'b0;
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
      @(posedge clk); #1;
      in_data = {24'd99, 24'd98};
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
      lat = 2;
      wait_strobe(lat);
      chk("ovr_latency", 64'(lat), 64'(5));
      chk("ovr_ch0", 64'(out_data[DS-1:0]), 64'(e0));
      chk("ovr_ch1", 64'(out_data[2*DS-1:DS]), 64'(e1));
      chk("ovr_flag", 64'(overrun), 64'(1));
      strobes = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_ready === 1'b1) strobes++;
      end
      chk("ovr_single_strobe", 64'(strobes), 64'(0));
      send(21, 22, 'h100, 1'b0, o0, o1);
      chk("ovr_next_at_wr1", 64'(o0), 64'(21));

      // Bypass across pointer wrap, then unity playback stays aligned
      for (int i = 1; i <= 20; i++) begin
         send(longint'(i), longint'(-i), 'h180, 1'b1, o0, o1);
         chk("byp_ch0", 64'(o0), 64'(i));
      end
      send(21, -21, 'h100, 1'b0, o0, o1);
      chk("wrap_ch0", 64'(o0), 64'(21));
      chk("wrap_ch1", 64'(o1), 64'hFFFFEB);
      chk("ovr_still_sticky", 64'(overrun), 64'(1));

      // Random samples, rates (including a frozen pointer) and bypass
      for (int i = 0; i < 60; i++) begin
         r0 = DS'($urandom);
         r1 = DS'($urandom);
         sf = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
         byp = ($urandom_range(0, 3) == 0);
         send(longint'($signed(r0)), longint'($signed(r1)), sf, byp, o0, o1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
